button_event_ctrl: RTL

- Multi-button input front end for the VGA controller board.
- Generates its own sample tick from the system clock and runs one debounce filter per button: an N-sample stable window on a shift register.
- Turns debounced edges and held keys into press/release/repeat events.
- Round-robin arbitrates pending events onto a single valid/ready event port that drives cursor and mode logic.

---
 rtl/button_event_ctrl_if.sv | 10 +
 rtl/button_event_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl_if.sv
// rtl/button_event_ctrl_if.sv - valid/ready event port between button front end and cursor/mode logic
interface button_event_ctrl_if;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_id;
    logic [1:0] event_type;

    modport master (output event_valid, output event_id, output event_type, input event_ready);
    modport slave  (input event_valid, input event_id, input event_type, output event_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced multi-button front end with press/release/repeat events
// Per-button pending slot feeds a round-robin arbiter onto a single valid/ready event port.
module button_event_ctrl #(
    parameter int N_BTN          = 4,
    parameter int CLK_DIV        = 50000,
    parameter int STABLE_SAMPLES = 8,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     noisy,
    output logic [N_BTN-1:0]     debounced,
    button_event_ctrl_if.master  ev,
    output logic [N_BTN-1:0]     overflow,
    input  logic                 clear_ovf
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam int PTR_W = $clog2(N_BTN);
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    logic [DIV_W-1:0]          div_cnt;
    logic                      tick;
    logic [N_BTN-1:0]          sync1, sync2;
    logic [STABLE_SAMPLES-1:0] shreg [N_BTN];
    logic [N_BTN-1:0]          deb_nxt, rise, fall, rep_hit, ev_new, pend, grant, drop;
    logic [REP_W-1:0]          rep_cnt [N_BTN];
    logic [1:0]                new_type [N_BTN];
    logic [1:0]                ptype [N_BTN];
    logic [PTR_W-1:0]          rr_ptr, pick, idx;
    logic                      found, load_ok;
    logic                      out_valid;
    logic [2:0]                out_id;
    logic [1:0]                out_type;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_BTN) s = s - N_BTN;
        return PTR_W'(s);
    endfunction

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sync1   <= '0;
            sync2   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            sync1   <= noisy;
            sync2   <= sync1;
        end
    end

    // Debounced level follows the window only when it is uniform; mixed patterns hold.
    always_comb begin
        deb_nxt = debounced;
        for (int i = 0; i < N_BTN; i++) begin
            if (&shreg[i])       deb_nxt[i] = 1'b1;
            else if (~|shreg[i]) deb_nxt[i] = 1'b0;
        end
    end

    assign rise = deb_nxt & ~debounced;
    assign fall = ~deb_nxt & debounced;

    always_comb begin
        rep_hit = '0;
        ev_new  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            new_type[i] = EV_REPEAT;
            rep_hit[i]  = tick && debounced[i] && deb_nxt[i] &&
                          (rep_cnt[i] == REP_W'(REPEAT_DELAY - 1));
            ev_new[i]   = rise[i] | fall[i] | rep_hit[i];
            if (rise[i])      new_type[i] = EV_PRESS;
            else if (fall[i]) new_type[i] = EV_RELEASE;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = wrap_add(rr_ptr, k);
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign load_ok = !out_valid || ev.event_ready;
    assign grant   = (load_ok && found) ? (N_BTN'(1) << pick) : '0;
    assign drop    = ev_new & pend & ~grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced <= '0;
            pend      <= '0;
            overflow  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                shreg[i]   <= '0;
                rep_cnt[i] <= '0;
                ptype[i]   <= '0;
            end
        end else begin
            debounced <= deb_nxt;
            overflow  <= (clear_ovf ? '0 : overflow) | drop;
            for (int i = 0; i < N_BTN; i++) begin
                if (tick) shreg[i] <= {shreg[i][STABLE_SAMPLES-2:0], sync2[i]};
                if (!debounced[i])
                    rep_cnt[i] <= '0;
                else if (tick)
                    rep_cnt[i] <= (rep_cnt[i] == REP_W'(REPEAT_DELAY - 1)) ?
                                  REP_W'(REPEAT_DELAY - REPEAT_RATE) : rep_cnt[i] + 1'b1;
                // A slot being granted this cycle frees up in time to take the new event.
                if (ev_new[i] && (!pend[i] || grant[i])) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= new_type[i];
                end else if (grant[i]) begin
                    pend[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_type  <= '0;
            rr_ptr    <= '0;
        end else if (load_ok) begin
            out_valid <= found;
            if (found) begin
                out_id   <= 3'(pick);
                out_type <= ptype[pick];
                rr_ptr   <= wrap_add(pick, 1);
            end
        end
    end

    assign ev.event_valid = out_valid;
    assign ev.event_id    = out_id;
    assign ev.event_type  = out_type;
endmodule
